sync_fifo_ext: RTL and testbench
================================

// Module: sync_fifo_ext
// PURPOSE
//  Parametrised single-clock FIFO, next generation of the basic fifo. Adds an occupancy count,
//  programmable almost-full/almost-empty flags, sticky overflow/underflow error flags,
//  a first-word-fall-through (FWFT) read mode, and read+write acceptance when full.
//  Sits between producer/consumer blocks on the same clk (UART, stream buffers, tests).
// PARAMETERS
//  ADDR_WIDTH  2   log2 of depth; DEPTH = 2**ADDR_WIDTH words (ADDR_WIDTH >= 1)
//  DATA_WIDTH  8   word width in bits
//  FWFT        0   0 = registered read (dout valid cycle after accepted read); 1 = fall-through
//  AF_LEVEL    DEPTH-1  almost_full asserted when count >= AF_LEVEL
//  AE_LEVEL    1   almost_empty asserted when count <= AE_LEVEL
// PORTS
//  clk           in   1             single clock, all logic on posedge
//  rst           in   1             synchronous, active-high reset
//  din           in   DATA_WIDTH    write data
//  wr_en         in   1             write request
//  rd_en         in   1             read request (FWFT: pop current head)
//  dout          out  DATA_WIDTH    read data
//  valid         out  1             dout holds a valid word (see BEHAVIOUR)
//  full          out  1             count == DEPTH
//  empty         out  1             count == 0
//  almost_full   out  1             count >= AF_LEVEL
//  almost_empty  out  1             count <= AE_LEVEL
//  count         out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
//  overflow      out  1             sticky: write rejected since last reset
//  underflow     out  1             sticky: read rejected since last reset
// BEHAVIOUR
//  - Reset (rst=1 at posedge): pointers, count=0; full=0, empty=1, almost_empty=1,
//    almost_full=(AF_LEVEL==0); overflow=underflow=0; dout=0, valid=0. Memory not cleared.
//  - Pointers ADDR_WIDTH bits, wrap DEPTH-1 -> 0 naturally; count kept as separate register.
//  - wr_acc = wr_en & (~full | rd_acc);  rd_acc = rd_en & ~empty. rd_acc never depends on wr.
//  - Full + wr_en + rd_en: both accepted, count unchanged, full stays 1.
//  - Empty + wr_en + rd_en: write accepted, read rejected -> underflow set, count 0->1.
//  - count' = count + wr_acc - rd_acc; all flags derived combinationally from the count register
//    (so they update the cycle after the accepted operation, zero extra latency).
//  - overflow set on wr_en & ~wr_acc; underflow set on rd_en & ~rd_acc; both cleared only by rst.
//  - Rejected operations change no data, pointer or count.
//  - FWFT=0: on rd_acc, dout <= mem[rd_ptr] at the edge (1-cycle latency); dout holds otherwise;
//    valid pulses 1 for the cycle after each rd_acc, else 0.
//  - FWFT=1: dout = mem[rd_ptr] continuously, valid = ~empty; rd_acc advances to the next word.
//    dout is don't-care while valid=0.
//  - Write and read of the same address in one cycle (only possible when full, FWFT=0): read
//    returns old word (read-before-write memory).
//  - rst mid-stream discards contents; in-flight requests in the rst cycle are ignored.
// STRUCTURE
//  - fifo_pkg: count width function clog2/ADDR_WIDTH+1 helper, FWFT mode constants
//    (FIFO_MODE_STD=0, FIFO_MODE_FWFT=1), shared with future async FIFO.
//  - One sub-module: fifo_ram (DEPTH x DATA_WIDTH simple dual-port, sync write, async read
//    port; top adds dout register in FWFT=0). Control/flags/count in sync_fifo_ext.
// TESTING  (ADDR_WIDTH=2, DATA_WIDTH=8, AF_LEVEL=3, AE_LEVEL=1 unless stated)
//  1 rst -> empty=1 full=0 count=0 almost_empty=1 overflow=0 underflow=0 dout=0 valid=0.
//  2 write 1,2,3,4 -> count 1,2,3,4; almost_full at count 3; full at 4; 5th write (9) ->
//    overflow=1, count stays 4; then 4 reads -> dout 1,2,3,4 with valid, empty=1.
//  3 full, wr_en=rd_en=1 din=5 -> count stays 4, full=1, dout=1, no overflow; drain gives 2,3,4,5.
//  4 empty, wr_en=rd_en=1 din=7 -> count=1, underflow=1, valid=0; next read -> dout=7.
//  5 FWFT=1: write 0xA5 -> next cycle valid=1 dout=0xA5 with no rd_en; write 0x3C, rd_en -> dout=0x3C.
//  6 fill to 3, assert rst with wr_en=1 -> count=0 empty=1 flags cleared; 100-cycle random
//    rd/wr vs. reference queue model, check dout/count/flags every cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode constants and the occupancy-count width helper.
// Kept separate so a future async FIFO can reuse the same constants.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // The count has to hold 0..DEPTH, so it needs one bit more than a pointer.
    function automatic int fifo_count_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write port and asynchronous read port.
// A read of the address being written in the same cycle returns the old word.
module fifo_ram #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with occupancy count, programmable almost flags, sticky
// overflow/underflow errors and a choice of registered or fall-through read.
module sync_fifo_ext
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8,
    parameter int FWFT       = FIFO_MODE_STD,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = fifo_count_width(ADDR_WIDTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    // Request semantics: wr_en/rd_en are requests, not a handshake. A request is
    // accepted in the cycle it is high if the FIFO can honour it (reads need a
    // stored word; writes need space or a simultaneous accepted read); otherwise
    // it is dropped and the matching sticky error flag is set.
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;

    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CW'(wr_acc) - CW'(rd_acc);
        overflow_d  = overflow_q | (wr_en & ~wr_acc);
        underflow_d = underflow_q | (rd_en & ~rd_acc);
        dout_d      = dout_q;
        valid_d     = rd_acc;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            if (FWFT == FIFO_MODE_STD) begin
                dout_d = ram_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
        end
    end

    // Writes are suppressed during reset so a request in the reset cycle leaves no trace.
    fifo_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (wr_acc & ~rst),
        .waddr(wr_ptr_q),
        .wdata(din),
        .raddr(rd_ptr_q),
        .rdata(ram_rdata)
    );

    assign dout  = (FWFT == FIFO_MODE_FWFT) ? ram_rdata : dout_q;
    assign valid = (FWFT == FIFO_MODE_FWFT) ? ~empty : valid_q;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Bench for sync_fifo_ext: a registered-read and a fall-through instance share one
// stimulus stream and are checked against a queue-based reference model.
module tb_sync_fifo_ext;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] din = '0;

    logic [7:0] dout0, dout1;
    logic       valid0, valid1, full0, full1, empty0, empty1;
    logic       af0, af1, ae0, ae1, ov0, ov1, un0, un1;
    logic [2:0] count0, count1;

    // Reference model: stored words, pending registered-read results, sticky errors.
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    logic       m_ov = 1'b0;
    logic       m_un = 1'b0;
    logic       mon_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sync_fifo_ext #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .FWFT(0), .AF_LEVEL(3), .AE_LEVEL(1)) dut0 (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout0), .valid(valid0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(count0),
        .overflow(ov0), .underflow(un0)
    );

    sync_fifo_ext #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(1)) dut1 (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout1), .valid(valid1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(count1),
        .overflow(ov1), .underflow(un1)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model advances with the same edge the DUTs see.
    task automatic cyc(input logic r, input logic w, input logic rd, input logic [7:0] d);
        bit ra, wa;
        rst = r; wr_en = w; rd_en = rd; din = d;
        @(posedge clk);
        if (r) begin
            mq.delete();
            exp_q.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
        end else begin
            ra = rd && (mq.size() > 0);
            wa = w && ((mq.size() < 4) || ra);
            if (ra) exp_q.push_back(mq.pop_front());
            if (wa) mq.push_back(d);
            if (w && !wa) m_ov = 1'b1;
            if (rd && !ra) m_un = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Monitor: flags every cycle, data whenever a DUT presents a valid word.
    always @(negedge clk) begin
        if (mon_en) begin
            int n;
            logic [7:0] e;
            n = mq.size();
            chk("count0", int'(count0), n);
            chk("count1", int'(count1), n);
            chk("full0", int'(full0), int'(n == 4));
            chk("full1", int'(full1), int'(n == 4));
            chk("empty0", int'(empty0), int'(n == 0));
            chk("empty1", int'(empty1), int'(n == 0));
            chk("almost_full0", int'(af0), int'(n >= 3));
            chk("almost_full1", int'(af1), int'(n >= 3));
            chk("almost_empty0", int'(ae0), int'(n <= 1));
            chk("almost_empty1", int'(ae1), int'(n <= 1));
            chk("overflow0", int'(ov0), int'(m_ov));
            chk("overflow1", int'(ov1), int'(m_ov));
            chk("underflow0", int'(un0), int'(m_un));
            chk("underflow1", int'(un1), int'(m_un));
            chk("valid0", int'(valid0), int'(exp_q.size() > 0));
            if (valid0 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("dout0", int'(dout0), int'(e));
            end
            chk("valid1", int'(valid1), int'(n > 0));
            if (valid1 && n > 0) chk("dout1", int'(dout1), int'(mq[0]));
        end
    end

    initial begin
        // 1: reset state
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        mon_en = 1'b1;
        chk("rst_dout0", int'(dout0), 0);
        chk("rst_valid0", int'(valid0), 0);

        // 2: fill, overflow on 5th write, drain
        for (int v = 1; v <= 4; v++) cyc(1'b0, 1'b1, 1'b0, 8'(v));
        chk("fill_count", int'(count0), 4);
        cyc(1'b0, 1'b1, 1'b0, 8'd9);
        chk("ovf_set", int'(ov0), 1);
        chk("ovf_count", int'(count0), 4);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 8'h00);
        idle(1);
        chk("drain_empty", int'(empty0), 1);

        // 3: read+write while full
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        for (int v = 1; v <= 4; v++) cyc(1'b0, 1'b1, 1'b0, 8'(v));
        cyc(1'b0, 1'b1, 1'b1, 8'd5);
        chk("rw_full_count", int'(count0), 4);
        chk("rw_full_dout", int'(dout0), 1);
        chk("rw_full_ovf", int'(ov0), 0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 8'h00);
        idle(1);

        // 4: read+write while empty
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b1, 8'd7);
        chk("rw_empty_count", int'(count0), 1);
        chk("rw_empty_unf", int'(un0), 1);
        chk("rw_empty_valid", int'(valid0), 0);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("rw_empty_dout", int'(dout0), 7);
        idle(1);

        // 5: fall-through head visible without a read
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'hA5);
        chk("fwft_valid", int'(valid1), 1);
        chk("fwft_dout_a5", int'(dout1), 8'hA5);
        cyc(1'b0, 1'b1, 1'b1, 8'h3C);
        chk("fwft_dout_3c", int'(dout1), 8'h3C);
        idle(1);

        // 6: reset mid-stream with a write pending, then random traffic
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        for (int v = 0; v < 3; v++) cyc(1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
        cyc(1'b1, 1'b1, 1'b0, 8'h55);
        chk("midrst_count", int'(count0), 0);
        chk("midrst_empty", int'(empty1), 1);
        for (int i = 0; i < 100; i++) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 100; i++) begin
            cyc(1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)));
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
